// File: rtl/serial_adder_ctrl_if.sv
// Request/response bundle for the bit-serial adder controller.
//   start, a, b, c_in : requester -> controller (operation request)
//   busy, done        : controller -> requester (status)
//   sum, c_out        : controller -> requester (registered result)
// master = requester side, slave = controller side.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller.
// Adds {c_out, sum} = a + b + c_in by time-multiplexing one 1-bit full-adder
// cell over WIDTH cycles, LSB first, recirculating the carry through a flop.
// Ports:
//   clock   : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : serial_adder_ctrl_if.slave (start/a/b/c_in in,
//             busy/done/sum/c_out out, all outputs registered)

// Gate-level 1-bit full adder cell.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  serial_adder_ctrl_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADD,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  // Holds the WIDTH-1 result bits produced so far; the final bit comes
  // straight from the cell on the completing edge.
  logic [WIDTH-2:0] res_sr_q, res_sr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;

  logic             fa_sum;
  logic             fa_c_out;
  logic [WIDTH-1:0] res_full;

  full_adder_cell u_fa (
    .a     (a_sr_q[0]),
    .b     (b_sr_q[0]),
    .c_in  (carry_q),
    .sum   (fa_sum),
    .c_out (fa_c_out)
  );

  assign res_full = {fa_sum, res_sr_q};

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    c_out_d  = c_out_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE accepts a new request exactly like IDLE for back-to-back use.
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          carry_d = bus.c_in;
          cnt_d   = '0;
          state_d = ST_ADD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADD: begin
        res_sr_d = res_full[WIDTH-1:1];
        carry_d  = fa_c_out;
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = res_full;
          c_out_d = fa_c_out;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      c_out_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      c_out_q  <= c_out_d;
    end
  end

  // Status is a pure decode of the state register, so no input reaches an
  // output combinationally and busy/done are mutually exclusive.
  assign bus.busy  = (state_q == ST_ADD);
  assign bus.done  = (state_q == ST_DONE);
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;
  logic clock;
  logic reset_n;
  int   checks;
  int   failures;

  // Last completed result the design should be presenting, {c_out, sum}.
  logic [8:0] hold8;
  logic [2:0] hold2;

  serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_adder_ctrl_if #(.WIDTH(2)) bus2 ();

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus8)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk8_status(input string tag, input logic busy_e, input logic done_e);
    chk({tag, "_busy"}, {31'd0, bus8.busy}, {31'd0, busy_e});
    chk({tag, "_done"}, {31'd0, bus8.done}, {31'd0, done_e});
    chk({tag, "_result"}, {23'd0, bus8.c_out, bus8.sum}, {23'd0, hold8});
  endtask

  // Drive a request at the current negedge, let the accepting edge pass,
  // then scramble the operand inputs to prove they are not re-sampled.
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c);
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    bus8.c_in  = c;
    @(negedge clock);
    bus8.start = 1'b0;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    bus8.c_in  = 1'($urandom);
    chk8_status("w8_e0", 1'b1, 1'b0);
  endtask

  // Walk edges E1..E8; optionally pulse start (0xFF+0xFF) after edge inj_k.
  // Returns at the negedge of the DONE cycle.
  task automatic finish8(input logic [8:0] exp, input int inj_k);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      bus8.start = 1'b0;
      if (k < 8) begin
        chk8_status("w8_add", 1'b1, 1'b0);
      end else begin
        hold8 = exp;
        chk8_status("w8_done", 1'b0, 1'b1);
      end
      if (k == inj_k) begin
        bus8.start = 1'b1;
        bus8.a     = 8'hFF;
        bus8.b     = 8'hFF;
      end
    end
  endtask

  task automatic idle8(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk8_status("w8_idle", 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    checks     = 0;
    failures   = 0;
    hold8      = '0;
    hold2      = '0;
    reset_n    = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.c_in = 1'b0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.c_in = 1'b0;

    // Reset then idle.
    #1;
    chk8_status("rst", 1'b0, 1'b0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    idle8(20);

    // Basic adds.
    start8(8'h3C, 8'h42, 1'b0); finish8(9'h07E, 0); idle8(2);
    start8(8'hFF, 8'h01, 1'b0); finish8(9'h100, 0); idle8(2);
    start8(8'hA5, 8'h5A, 1'b1); finish8(9'h100, 0); idle8(2);

    // Start during busy: pulse driven in the 3rd ADD cycle is ignored.
    start8(8'h01, 8'h01, 1'b0); finish8(9'h002, 2); idle8(10);

    // Back-to-back: new request during the DONE cycle.
    start8(8'h10, 8'h20, 1'b0); finish8(9'h030, 0);
    start8(8'h80, 8'h80, 1'b1); finish8(9'h101, 0); idle8(2);

    // Reset mid-operation, asserted asynchronously in the 4th ADD cycle.
    start8(8'h7F, 8'h01, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      chk8_status("w8_pre_rst", 1'b1, 1'b0);
    end
    #2;
    reset_n = 1'b0;
    hold8   = '0;
    #1;
    chk8_status("w8_mid_rst", 1'b0, 1'b0);
    repeat (2) @(negedge clock);
    chk8_status("w8_in_rst", 1'b0, 1'b0);
    reset_n = 1'b1;
    idle8(10);
    start8(8'h10, 8'h20, 1'b0); finish8(9'h030, 0); idle8(1);

    // Randomized operations, mixing idle gaps and back-to-back requests.
    for (int n = 0; n < 24; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      start8(ra, rb, rc);
      finish8(9'(ra) + 9'(rb) + 9'(rc), 0);
      if ($urandom_range(0, 1) == 0) idle8($urandom_range(1, 3));
    end
    idle8(1);

    // Exhaustive WIDTH=2 sweep: latency 2 edges, result = a+b+c_in.
    for (int v = 0; v < 32; v++) begin
      bus2.start = 1'b1;
      bus2.a     = 2'(v >> 3);
      bus2.b     = 2'(v >> 1);
      bus2.c_in  = 1'(v);
      @(negedge clock);
      bus2.start = 1'b0;
      chk("w2_e0_busy", {31'd0, bus2.busy}, 32'd1);
      chk("w2_e0_result", {29'd0, bus2.c_out, bus2.sum}, {29'd0, hold2});
      @(negedge clock);
      chk("w2_e1_busy", {31'd0, bus2.busy}, 32'd1);
      chk("w2_e1_done", {31'd0, bus2.done}, 32'd0);
      @(negedge clock);
      hold2 = 3'(v >> 3) + 3'((v >> 1) & 3) + 3'(v & 1);
      chk("w2_e2_done", {31'd0, bus2.done}, 32'd1);
      chk("w2_e2_busy", {31'd0, bus2.busy}, 32'd0);
      chk("w2_e2_result", {29'd0, bus2.c_out, bus2.sum}, {29'd0, hold2});
      @(negedge clock);
      chk("w2_idle_done", {31'd0, bus2.done}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
